// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the decode-stage issue controller: register-file
// geometry, architectural register aliases and the controller state type.
package pipe_hazard_ctrl_pkg;

  localparam int NREG   = 16;
  localparam int REG_AW = 4;

  localparam logic [REG_AW-1:0] LR = 4'd14;
  localparam logic [REG_AW-1:0] PC = 4'd15;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_reg_scoreboard.sv
// Register scoreboard: one busy bit per architectural register.
// Lookups see writebacks retiring this cycle (the register file writes in the
// first half-cycle), and a new destination set beats a same-cycle retire.
module reg_scoreboard #(
  parameter int NREG = pipe_hazard_ctrl_pkg::NREG
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  wb_valid,
  input  logic [pipe_hazard_ctrl_pkg::REG_AW-1:0] wb_addr,
  input  logic                                  set_en,
  input  logic [pipe_hazard_ctrl_pkg::REG_AW-1:0] set_addr,
  input  logic [pipe_hazard_ctrl_pkg::REG_AW-1:0] rd1_addr,
  input  logic [pipe_hazard_ctrl_pkg::REG_AW-1:0] rd2_addr,
  input  logic [pipe_hazard_ctrl_pkg::REG_AW-1:0] wr_addr,
  output logic                                  rd1_busy,
  output logic                                  rd2_busy,
  output logic                                  wr_busy,
  output logic [NREG-1:0]                       busy_mask
);
  import pipe_hazard_ctrl_pkg::*;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr_1h;
  logic [NREG-1:0] set_1h;
  logic [NREG-1:0] busy_eff;

  function automatic logic [NREG-1:0] onehot(input logic en, input logic [REG_AW-1:0] a);
    logic [NREG-1:0] m;
    m = '0;
    for (int i = 0; i < NREG; i++) begin
      if (en && (a == i[REG_AW-1:0])) m[i] = 1'b1;
    end
    return m;
  endfunction

  assign clr_1h   = onehot(wb_valid, wb_addr);
  assign set_1h   = onehot(set_en, set_addr);
  assign busy_eff = busy & ~clr_1h;

  assign rd1_busy  = busy_eff[rd1_addr];
  assign rd2_busy  = busy_eff[rd2_addr];
  assign wr_busy   = busy_eff[wr_addr];
  assign busy_mask = busy;

  // Retire writebacks, then mark newly issued destinations busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_eff | set_1h;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Decode-stage issue controller: holds decode on RAW/WAW hazards against
// in-flight register writes and kills the fetch/decode path for a fixed
// number of cycles after a taken branch issues.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NREG         = pipe_hazard_ctrl_pkg::NREG,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dec_valid,
  input  logic              dec_rd1_en,
  input  logic              dec_rd2_en,
  input  logic [REG_AW-1:0] dec_rd1_addr,
  input  logic [REG_AW-1:0] dec_rd2_addr,
  input  logic              dec_wr_en,
  input  logic [REG_AW-1:0] dec_wr_addr,
  input  logic              dec_branch_taken,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  output logic              issue,
  output logic              stall,
  output logic              flush,
  output logic [NREG-1:0]   busy_mask
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rd1_busy;
  logic             rd2_busy;
  logic             wr_busy;
  logic             hazard;

  reg_scoreboard #(
    .NREG (NREG)
  ) u_sb (
    .clk       (clk),
    .reset_n   (reset_n),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .set_en    (issue & dec_wr_en),
    .set_addr  (dec_wr_addr),
    .rd1_addr  (dec_rd1_addr),
    .rd2_addr  (dec_rd2_addr),
    .wr_addr   (dec_wr_addr),
    .rd1_busy  (rd1_busy),
    .rd2_busy  (rd2_busy),
    .wr_busy   (wr_busy),
    .busy_mask (busy_mask)
  );

  assign hazard = (dec_rd1_en & rd1_busy) | (dec_rd2_en & rd2_busy) | (dec_wr_en & wr_busy);
  assign flush  = (state == FLUSH);

  // Issue/stall decision; decode is ignored entirely while flushing.
  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    if (state == RUN) begin
      issue = dec_valid & ~hazard;
      stall = dec_valid & hazard;
    end
  end

  // Branch flush sequencer: count down FLUSH_CYCLES kill cycles, then resume.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (issue && dec_branch_taken) begin
            state <= FLUSH;
            cnt   <= CNT_W'(FLUSH_CYCLES);
          end
        end
        FLUSH: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= RUN;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle-by-cycle vector table plus
// hand-written reset sequences.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        dec_valid = 1'b0, dec_rd1_en = 1'b0, dec_rd2_en = 1'b0;
  logic [3:0]  dec_rd1_addr = '0, dec_rd2_addr = '0;
  logic        dec_wr_en = 1'b0;
  logic [3:0]  dec_wr_addr = '0;
  logic        dec_branch_taken = 1'b0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic        issue, stall, flush;
  logic [15:0] busy_mask;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       v, r1e;  logic [3:0] r1a;
    logic       r2e;     logic [3:0] r2a;
    logic       we;      logic [3:0] wa;
    logic       br, wbv; logic [3:0] wba;
    logic       e_issue, e_stall, e_flush;
    logic [15:0] e_busy;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  pipe_hazard_ctrl #(.NREG(16), .FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .dec_valid        (dec_valid),
    .dec_rd1_en       (dec_rd1_en),
    .dec_rd2_en       (dec_rd2_en),
    .dec_rd1_addr     (dec_rd1_addr),
    .dec_rd2_addr     (dec_rd2_addr),
    .dec_wr_en        (dec_wr_en),
    .dec_wr_addr      (dec_wr_addr),
    .dec_branch_taken (dec_branch_taken),
    .wb_valid         (wb_valid),
    .wb_addr          (wb_addr),
    .issue            (issue),
    .stall            (stall),
    .flush            (flush),
    .busy_mask        (busy_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    input logic v, input logic r1e, input logic [3:0] r1a,
    input logic r2e, input logic [3:0] r2a,
    input logic we, input logic [3:0] wa, input logic br,
    input logic wbv, input logic [3:0] wba,
    input logic ei, input logic es, input logic ef, input logic [15:0] eb);
    vec_t r;
    r.v = v; r.r1e = r1e; r.r1a = r1a; r.r2e = r2e; r.r2a = r2a;
    r.we = we; r.wa = wa; r.br = br; r.wbv = wbv; r.wba = wba;
    r.e_issue = ei; r.e_stall = es; r.e_flush = ef; r.e_busy = eb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t r);
    dec_valid = r.v;   dec_rd1_en = r.r1e; dec_rd1_addr = r.r1a;
    dec_rd2_en = r.r2e; dec_rd2_addr = r.r2a;
    dec_wr_en = r.we;  dec_wr_addr = r.wa;
    dec_branch_taken = r.br;
    wb_valid = r.wbv;  wb_addr = r.wba;
  endtask

  initial begin
    vec_t idle;
    //               v r1e r1a  r2e r2a  we wa  br wbv wba   iss stl fl busy
    tbl[0]  = mk(1, 1, 4'd1,  1, 4'd2,  0, 4'd0,  0, 0, 4'd0,  1, 0, 0, 16'h0000);
    tbl[1]  = mk(1, 0, 4'd0,  0, 4'd0,  1, 4'd3,  0, 0, 4'd0,  1, 0, 0, 16'h0000);
    tbl[2]  = mk(1, 1, 4'd3,  0, 4'd0,  0, 4'd0,  0, 0, 4'd0,  0, 1, 0, 16'h0008);
    tbl[3]  = mk(1, 1, 4'd3,  0, 4'd0,  0, 4'd0,  0, 1, 4'd3,  1, 0, 0, 16'h0008);
    tbl[4]  = mk(0, 0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 0, 4'd0,  0, 0, 0, 16'h0000);
    tbl[5]  = mk(1, 0, 4'd0,  0, 4'd0,  1, 4'd5,  0, 0, 4'd0,  1, 0, 0, 16'h0000);
    tbl[6]  = mk(1, 0, 4'd0,  0, 4'd0,  1, 4'd5,  0, 0, 4'd0,  0, 1, 0, 16'h0020);
    tbl[7]  = mk(1, 0, 4'd0,  0, 4'd0,  1, 4'd5,  0, 1, 4'd5,  1, 0, 0, 16'h0020);
    tbl[8]  = mk(1, 1, 4'd5,  0, 4'd0,  0, 4'd0,  0, 1, 4'd5,  1, 0, 0, 16'h0020);
    tbl[9]  = mk(1, 0, 4'd0,  0, 4'd0,  1, LR,    1, 0, 4'd0,  1, 0, 0, 16'h0000);
    tbl[10] = mk(1, 1, 4'd1,  0, 4'd0,  0, 4'd0,  0, 0, 4'd0,  0, 0, 1, 16'h4000);
    tbl[11] = mk(1, 1, 4'd1,  0, 4'd0,  0, 4'd0,  0, 0, 4'd0,  0, 0, 1, 16'h4000);
    tbl[12] = mk(1, 1, LR,    0, 4'd0,  0, 4'd0,  0, 0, 4'd0,  0, 1, 0, 16'h4000);
    tbl[13] = mk(1, 1, LR,    0, 4'd0,  0, 4'd0,  0, 1, LR,    1, 0, 0, 16'h4000);
    tbl[14] = mk(0, 0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 1, 4'd9,  0, 0, 0, 16'h0000);
    tbl[15] = mk(1, 0, 4'd0,  0, 4'd0,  1, 4'd7,  0, 0, 4'd0,  1, 0, 0, 16'h0000);
    tbl[16] = mk(1, 1, 4'd7,  0, 4'd0,  0, 4'd0,  1, 0, 4'd0,  0, 1, 0, 16'h0080);
    tbl[17] = mk(1, 1, 4'd7,  0, 4'd0,  0, 4'd0,  1, 0, 4'd0,  0, 1, 0, 16'h0080);
    tbl[18] = mk(1, 1, 4'd7,  0, 4'd0,  0, 4'd0,  1, 1, 4'd7,  1, 0, 0, 16'h0080);
    tbl[19] = mk(1, 1, 4'd1,  0, 4'd0,  0, 4'd0,  0, 0, 4'd0,  0, 0, 1, 16'h0000);
    tbl[20] = mk(1, 1, 4'd1,  0, 4'd0,  0, 4'd0,  0, 0, 4'd0,  0, 0, 1, 16'h0000);
    tbl[21] = mk(1, 0, 4'd0,  0, 4'd0,  1, 4'd2,  0, 0, 4'd0,  1, 0, 0, 16'h0000);
    tbl[22] = mk(1, 0, 4'd0,  1, 4'd2,  0, 4'd0,  0, 0, 4'd0,  0, 1, 0, 16'h0004);
    tbl[23] = mk(1, 0, 4'd0,  0, 4'd2,  0, 4'd0,  0, 0, 4'd0,  1, 0, 0, 16'h0004);
    tbl[24] = mk(0, 0, 4'd0,  0, 4'd0,  0, 4'd0,  0, 1, 4'd2,  0, 0, 0, 16'h0004);
    idle = mk(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 16'h0000);

    // Reset held with random inputs.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      dec_valid = 1'($urandom);  dec_rd1_en = 1'($urandom); dec_rd2_en = 1'($urandom);
      dec_rd1_addr = 4'($urandom); dec_rd2_addr = 4'($urandom);
      dec_wr_en = 1'($urandom);  dec_wr_addr = 4'($urandom);
      dec_branch_taken = 1'($urandom);
      wb_valid = 1'($urandom);   wb_addr = 4'($urandom);
      @(negedge clk);
      chk("rst_busy", 32'(busy_mask), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
    end
    drive(idle);
    #1;
    chk("rst_issue_idle", 32'(issue), 32'h0);
    chk("rst_stall_idle", 32'(stall), 32'h0);
    reset_n = 1'b1;

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d_issue", i), 32'(issue), 32'(tbl[i].e_issue));
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
      chk($sformatf("v%0d_busy", i), 32'(busy_mask), 32'(tbl[i].e_busy));
    end

    // Reset during the second flush cycle of a BL.
    @(posedge clk); #1;
    drive(mk(1, 0, 4'd0, 0, 4'd0, 1, LR, 1, 0, 4'd0, 0, 0, 0, 16'h0));
    @(negedge clk);
    chk("bl2_issue", 32'(issue), 32'h1);
    chk("bl2_busy_pre", 32'(busy_mask), 32'h0);
    @(posedge clk); #1;
    drive(mk(1, 1, 4'd1, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 16'h0));
    @(negedge clk);
    chk("bl2_flush1", 32'(flush), 32'h1);
    chk("bl2_busy_lr", 32'(busy_mask), 32'h4000);
    @(posedge clk); #1;
    chk("bl2_flush2", 32'(flush), 32'h1);
    drive(idle);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_flush", 32'(flush), 32'h0);
    chk("midrst_busy", 32'(busy_mask), 32'h0);
    chk("midrst_issue", 32'(issue), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    drive(mk(0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 1, LR, 0, 0, 0, 16'h0));
    @(negedge clk);
    chk("postrst_wb_busy", 32'(busy_mask), 32'h0);
    @(posedge clk); #1;
    drive(mk(1, 1, LR, 0, 4'd0, 0, 4'd0, 0, 0, 4'd0, 0, 0, 0, 16'h0));
    @(negedge clk);
    chk("postrst_busy", 32'(busy_mask), 32'h0);
    chk("postrst_flush", 32'(flush), 32'h0);
    chk("postrst_issue", 32'(issue), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Issue controller for the decode stage of the pipelined ARM core. It tracks which register-file destinations have writes in flight (a scoreboard) and holds the decode stage on read-after-write and write-after-write hazards. After a taken branch it flushes the fetch/decode path for a fixed number of cycles. It sits between the decoder's register-read requests and the writeback stage's register-write port.

## Interface
- NREG, 16, number of architectural registers tracked
- FLUSH_CYCLES, 2, cycles of fetch/decode kill after a taken branch issues; must be ≥1

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode stage holds a valid, condition-passed instruction
- dec_rd1_en, dec_rd2_en  in  1 each  source read port used
- dec_rd1_addr, dec_rd2_addr  in  4 each  source register numbers
- dec_wr_en  in  1  instruction will write a register at writeback (includes the BL link write to r14)
- dec_wr_addr  in  4  destination register
- dec_branch_taken  in  1  instruction is a taken branch
- wb_valid  in  1  writeback retires a register write this cycle
- wb_addr  in  4  register being retired
- issue  out  1  decode instruction advances this cycle
- stall  out  1  hold PC, fetch and decode registers
- flush  out  1  kill the instruction leaving fetch
- busy_mask  out  NREG  scoreboard contents (registered)

## Operation
- Scoreboard: one bit per register; `busy_eff = busy & ~(wb_valid ? 1<<wb_addr : 0)`. This is a same-cycle write-through bypass: the register file writes in the first half-cycle.
- hazard = (rd1_en & busy_eff[rd1_addr]) | (rd2_en & busy_eff[rd2_addr]) | (dec_wr_en & busy_eff[dec_wr_addr]).
- FSM states RUN and FLUSH.
  - RUN:
    - issue = dec_valid & ~hazard.
    - stall = dec_valid & hazard.
    - flush = 0.
  - RUN → FLUSH when issue & dec_branch_taken. The flush counter loads FLUSH_CYCLES.
  - FLUSH:
    - issue = 0, stall = 0, flush = 1. dec_valid is ignored.
    - The counter decrements each cycle. When it reaches 0, return to RUN.
- Scoreboard update each edge: busy ← (busy & clear_mask) | set_mask.
  - set_mask = issue & dec_wr_en ? 1<<dec_wr_addr : 0.
  - Set wins over clear on the same register in the same cycle.
- wb_valid to a register that is not busy: ignored, with no side effects.
- A branch held by a stall does not flush until it issues.
- A taken branch with dec_wr_en (BL) marks its destination busy and also enters FLUSH.

## Timing
- Reset (async, reset_n=0):
  - busy_mask=0, state RUN, counter=0.
  - Hence issue=0, stall=0, flush=0 while dec_valid=0.
- issue and stall are combinational from inputs and registered state, with zero-cycle latency.
- flush is decoded from the registered state only. It is high for exactly FLUSH_CYCLES cycles, starting the cycle after the branch issues.
- A retiring write unblocks a dependent reader in the same cycle as wb_valid.
- Reset asserted mid-FLUSH or with writes in flight: all state clears immediately. Pending writebacks after reset are ignored.
- Counter width is $clog2(FLUSH_CYCLES+1). There is no wrap; decrement stops at 0.

## Structure
- Shared package holds:
  - NREG and REG_AW=4
  - constants LR=4'd14 and PC=4'd15
  - the state enum {RUN, FLUSH}
- One natural sub-module is reg_scoreboard, which contains the busy vector, set/clear logic and bypassed lookups for three addresses.
- The FSM and the flush counter live in the top level.

## Test plan
- Reset: hold reset_n=0 with random inputs → busy_mask=0, flush=0. Release with dec_valid=1 and reads of r1/r2 → issue=1 on the first cycle.
- RAW:
  - Issue a write to r3, then a read of r3 the next cycle → stall=1, issue=0.
  - Pulse wb_valid with wb_addr=3 → issue=1 in that same cycle, and busy_mask[3]=0 afterwards.
- WAW plus simultaneous set/clear:
  - With r5 busy, a new write to r5 stalls.
  - With wb_addr=5 in the same cycle, the write issues and busy_mask[5] stays 1.
- BL with FLUSH_CYCLES=2: issue a taken branch with a write to r14 → flush=1 for exactly 2 cycles, issue=0 despite dec_valid=1, and busy_mask[14]=1. The next cycle is back in RUN.
- Stalled branch:
  - A taken branch that reads busy r7 → stall and no flush.
  - Retire r7 → the branch issues, then flush for 2 cycles.
- Reset mid-flush: assert reset_n=0 during the second flush cycle → flush=0 and busy_mask=0 immediately. wb_valid to r14 afterwards causes no change.
